fp_alu_cmd_ctrl: RTL

Sequential command front-end for the combinational `fp_alu`. It accepts floating-point operation commands over a valid/ready handshake and drives the ALU operand and opcode inputs from registers. It holds them for a fixed multicycle settle window, then captures the ALU result into a 2-deep response buffer. The response buffer is drained over a second valid/ready handshake. The block sits between any command-issuing master and `fp_alu`, and is the responder end of the ALU operand/result interface.

---
 rtl/fp_alu_cmd_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/fp_alu_cmd_ctrl.sv
// Command front-end for the combinational fp_alu: registers operands, waits a settle window,
// captures the result into a 2-deep response FIFO. Optional FP_ALU_EXC_FLAGS_EN adds rsp_flags_o.
module fp_alu_cmd_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [31:0] cmd_a_i,
    input  logic [31:0] cmd_b_i,
    input  logic [1:0]  cmd_op_i,
    input  logic        cmd_sub_i,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    output logic [1:0]  alu_opcode_o,
    output logic        alu_add_sub_o,
    input  logic [31:0] alu_result_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_result_o,
    output logic        rsp_err_o,
`ifdef FP_ALU_EXC_FLAGS_EN
    output logic [2:0]  rsp_flags_o,
`endif
    output logic        busy_o
);

    // state   | meaning
    // ST_IDLE | waiting for a command; accepts only while the response buffer has room
    // ST_WAIT | alu_* held stable while the settle counter runs down, then capture

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [31:0] QNAN        = 32'h7FC0_0000;

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              err_q;
    logic [31:0]       alu_a_q;
    logic [31:0]       alu_b_q;
    logic [1:0]        alu_op_q;
    logic              alu_sub_q;

    logic [1:0][31:0]  buf_res_q;
    logic [1:0]        buf_err_q;
    logic              wptr_q;
    logic              rptr_q;
    logic [1:0]        count_q;
    logic [1:0]        count_d;

    logic              accept;
    logic              push;
    logic              pop;
    logic [31:0]       cap_res;

`ifdef FP_ALU_EXC_FLAGS_EN
    logic [1:0][2:0]   buf_flags_q;
    logic [2:0]        cap_flags;

    function automatic logic [2:0] classify(input logic [31:0] v);
        logic exp_ones;
        logic exp_zero;
        logic man_zero;
        exp_ones = (v[30:23] == 8'hFF);
        exp_zero = (v[30:23] == 8'h00);
        man_zero = (v[22:0] == 23'd0);
        return {exp_ones && !man_zero, exp_ones && man_zero, exp_zero && man_zero};
    endfunction

    assign cap_flags   = err_q ? 3'b100 : classify(cap_res);
    assign rsp_flags_o = buf_flags_q[rptr_q];
`endif

    // Ready never looks at cmd_valid_i, so a master may wait on it without a loop.
    assign cmd_ready_o = (state_q == ST_IDLE) && (count_q < 2'd2) && !rst_i;
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign push        = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    assign pop         = rsp_valid_o && rsp_ready_i;
    assign cap_res     = err_q ? QNAN : alu_result_i;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            alu_sub_q   <= 1'b0;
            buf_res_q   <= '0;
            buf_err_q   <= '0;
            wptr_q      <= 1'b0;
            rptr_q      <= 1'b0;
            count_q     <= '0;
`ifdef FP_ALU_EXC_FLAGS_EN
            buf_flags_q <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        alu_a_q   <= cmd_a_i;
                        alu_b_q   <= cmd_b_i;
                        alu_op_q  <= cmd_op_i;
                        alu_sub_q <= cmd_sub_i;
                        err_q     <= (cmd_op_i == 2'b11);
                        cnt_q     <= SETTLE_LOAD;
                        state_q   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (push) begin
                buf_res_q[wptr_q]   <= cap_res;
                buf_err_q[wptr_q]   <= err_q;
`ifdef FP_ALU_EXC_FLAGS_EN
                buf_flags_q[wptr_q] <= cap_flags;
`endif
                wptr_q              <= ~wptr_q;
            end
            if (pop) begin
                rptr_q <= ~rptr_q;
            end
            count_q <= count_d;
        end
    end

    assign alu_a_o       = alu_a_q;
    assign alu_b_o       = alu_b_q;
    assign alu_opcode_o  = alu_op_q;
    assign alu_add_sub_o = alu_sub_q;
    assign rsp_valid_o   = (count_q != 2'd0);
    assign rsp_result_o  = buf_res_q[rptr_q];
    assign rsp_err_o     = buf_err_q[rptr_q];
    assign busy_o        = (state_q == ST_WAIT);

endmodule
